axilite4_sram_ctrl: RTL and testbench
=====================================

# axilite4_sram_ctrl

AXI Lite 4 slave front-end that schedules the independent read and write channels onto a single-port, 128-bit-wide SRAM macro. It sits between the slave side of the AXI Lite 4 bus mux and the memory array, replacing dual-ported access with a round-robin arbitrated, one-transaction-at-a-time FSM. Read and write requests are ordered strictly in acceptance order, so a read accepted after a write always observes that write.

## Interface
- memAddrWidth, 16, byte-address bits decoded by the memory. Macro depth is 2^(memAddrWidth-4) lines of 16 bytes.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- readAddr_addr  in  32  read byte address
- readAddr_valid / readAddr_ready  in / out  1  read address handshake
- readData_data  out  128  read line
- readData_valid / readData_ready  out / in  1  read data handshake
- writeAddr_addr  in  32  write byte address
- writeAddr_valid / writeAddr_ready  in / out  1  write address handshake
- writeData_data  in  128  write line
- writeData_strb  in  16  byte enables; bit i covers data[8i+7:8i]
- writeData_valid / writeData_ready  in / out  1  write data handshake
- writeResp_msg  out  32  0 = OKAY, 2 = SLVERR
- writeResp_valid / writeResp_ready  out / in  1  write response handshake
- mem_en  out  1  macro access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  memAddrWidth-4  line index, taken from addr[memAddrWidth-1:4]
- mem_wdata  out  128  write line
- mem_wmask  out  16  byte write mask (= strb)
- mem_rdata  in  128  read line, valid exactly one cycle after a read strobe
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, RD_MEM, RD_CAP, RD_RESP, WR_MEM, WR_RESP.
- A read candidate exists when readAddr_valid is high.
- A write candidate exists only when writeAddr_valid and writeData_valid are both high. Address and data are always accepted in the same cycle.
- Arbitration happens in IDLE only:
  - If exactly one candidate exists, it wins.
  - If both exist, the type not served last wins.
  - last_grant updates on every acceptance.
- readAddr_ready = IDLE && read granted. writeAddr_ready = writeData_ready = IDLE && write granted. All readies are low outside IDLE.
- Read path:
  - Acceptance latches the address. IDLE→RD_MEM.
  - RD_MEM: mem_en=1, mem_we=0. →RD_CAP.
  - RD_CAP: mem_rdata is latched into readData_data. →RD_RESP.
  - RD_RESP: readData_valid=1, data held stable until readData_ready is seen, then →IDLE.
- Write path:
  - Acceptance latches address, data and strb. IDLE→WR_MEM.
  - WR_MEM: mem_en=1, mem_we=1, mem_wmask=strb. →WR_RESP.
  - WR_RESP: writeResp_valid=1, msg held until writeResp_ready is seen, then →IDLE.
- Out-of-range address: addr[31:memAddrWidth] != 0.
  - mem_en stays 0 in RD_MEM/WR_MEM.
  - A read returns all-zero data.
  - A write returns msg=2. In-range writes return msg=0.
- addr[3:0] is ignored; every access is line-aligned.
- A write with strb=0 still performs the macro cycle (mask 0) and returns OKAY.
- mem_addr, mem_wdata and mem_wmask come from the latched registers. They hold their values outside access states, but only mem_en qualifies them.

## Timing
- Reset values: state=IDLE; every ready and valid = 0; readData_data=0; writeResp_msg=0; mem_en=0, mem_we=0; busy=0. last_grant=write, so the first tie goes to read.
- Read latency: handshake at edge T; mem_en during T+1; line latched at end of T+2; readData_valid high from T+3.
- Write latency: handshake at T; macro write during T+1; writeResp_valid high from T+2.
- Throughput: at best one read per 4 cycles and one write per 3 cycles, counting the return to IDLE.
- A new request can be accepted in the cycle after the response handshake.
- Simultaneous read and write candidates: exactly one is accepted. The loser's valid must be held by the master and is served next.
- Reset during any state: the state register is IDLE at the next edge. An access strobed in the current cycle still completes at the macro, but its response is discarded, and no valid is asserted after the reset edge.
- Outputs depend only on registered state, never combinationally on inputs, except the three readies. Those depend on the valids through arbitration.

## Test plan
- Write addr 0x20, data 0x00112233_44556677_8899AABB_CCDDEEFF, strb 0xFFFF, then read 0x20 → mem_en at T+1 with mem_addr=2; writeResp msg=0 at T+2; readData equals the written line at T+3 after the read handshake.
- Partial strobe: write 0xFF..FF with strb 0x000F to line 0, then read 0x00 → mem_wmask=0x000F; only bytes 0–3 change.
- Read and write candidates both valid in the same cycle after reset → read accepted first. With both still pending afterwards, the next grants alternate write, read, write.
- Out of range: read 0x0001_0000 and write 0x0001_0040 → mem_en never asserted; readData=0; writeResp_msg=2.
- Backpressure: hold readData_ready=0 for 5 cycles → readData_valid and data stable throughout; no new request accepted; busy=1.
- Assert rst for one cycle while in WR_MEM → next cycle in IDLE; writeResp_valid never rises; all outputs at reset values.

Source files
------------

// File: rtl/axilite4_sram_ctrl.sv
`timescale 1ns/1ps
// AXI Lite 4 slave that serialises the read and write channels onto one
// single-port 128-bit SRAM macro, one transaction at a time.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   readAddr_*                    read address channel (addr/valid/ready)
//   readData_*                    read data channel (data/valid/ready)
//   writeAddr_*, writeData_*      write address and data channels
//   writeResp_*                   write response (msg 0=OKAY, 2=SLVERR)
//   mem_en/we/addr/wdata/wmask    macro request, mem_rdata one cycle later
//   busy                          high whenever the controller is not idle
module axilite4_sram_ctrl #(
  parameter int memAddrWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             readAddr_addr,
  input  logic                    readAddr_valid,
  output logic                    readAddr_ready,
  output logic [127:0]            readData_data,
  output logic                    readData_valid,
  input  logic                    readData_ready,
  input  logic [31:0]             writeAddr_addr,
  input  logic                    writeAddr_valid,
  output logic                    writeAddr_ready,
  input  logic [127:0]            writeData_data,
  input  logic [15:0]             writeData_strb,
  input  logic                    writeData_valid,
  output logic                    writeData_ready,
  output logic [31:0]             writeResp_msg,
  output logic                    writeResp_valid,
  input  logic                    writeResp_ready,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [memAddrWidth-5:0] mem_addr,
  output logic [127:0]            mem_wdata,
  output logic [15:0]             mem_wmask,
  input  logic [127:0]            mem_rdata,
  output logic                    busy
);

  localparam int LW = memAddrWidth - 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_MEM  = 3'd1;
  localparam logic [2:0] S_RD_CAP  = 3'd2;
  localparam logic [2:0] S_RD_RESP = 3'd3;
  localparam logic [2:0] S_WR_MEM  = 3'd4;
  localparam logic [2:0] S_WR_RESP = 3'd5;

  localparam logic [31:0] RESP_OKAY   = 32'd0;
  localparam logic [31:0] RESP_SLVERR = 32'd2;

  logic [2:0]    state_q, state_d;
  logic          last_wr_q, last_wr_d;
  logic [LW-1:0] line_q, line_d;
  logic          oor_q, oor_d;
  logic [127:0]  wdata_q, wdata_d;
  logic [15:0]   strb_q, strb_d;
  logic [127:0]  rdata_q, rdata_d;
  logic [31:0]   msg_q, msg_d;

  logic is_idle;
  logic rd_cand;
  logic wr_cand;
  logic grant_rd;
  logic grant_wr;
  logic rd_oor;
  logic wr_oor;

  // Byte offset within a line is never used: every access is line-aligned.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};

  assign is_idle = (state_q == S_IDLE);
  assign rd_cand = readAddr_valid;
  assign wr_cand = writeAddr_valid & writeData_valid;

  // On a tie the type that was not served last wins.
  assign grant_rd = is_idle & rd_cand & (~wr_cand | last_wr_q);
  assign grant_wr = is_idle & wr_cand & ~grant_rd;

  assign rd_oor = |readAddr_addr[31:memAddrWidth];
  assign wr_oor = |writeAddr_addr[31:memAddrWidth];

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    line_d    = line_q;
    oor_d     = oor_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    msg_d     = msg_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          grant_rd: begin
            state_d   = S_RD_MEM;
            last_wr_d = 1'b0;
            line_d    = readAddr_addr[memAddrWidth-1:4];
            oor_d     = rd_oor;
          end
          grant_wr: begin
            state_d   = S_WR_MEM;
            last_wr_d = 1'b1;
            line_d    = writeAddr_addr[memAddrWidth-1:4];
            oor_d     = wr_oor;
            wdata_d   = writeData_data;
            strb_d    = writeData_strb;
            msg_d     = wr_oor ? RESP_SLVERR : RESP_OKAY;
          end
          default: ;
        endcase
      end
      S_RD_MEM: state_d = S_RD_CAP;
      S_RD_CAP: begin
        // Out-of-range reads never strobed the macro; return zeros.
        rdata_d = oor_q ? '0 : mem_rdata;
        state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (readData_ready) state_d = S_IDLE;
      end
      S_WR_MEM: state_d = S_WR_RESP;
      S_WR_RESP: begin
        if (writeResp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b1;
      line_q    <= '0;
      oor_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      msg_q     <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      line_q    <= line_d;
      oor_q     <= oor_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      msg_q     <= msg_d;
    end
  end

  assign readAddr_ready  = grant_rd;
  assign writeAddr_ready = grant_wr;
  assign writeData_ready = grant_wr;

  assign readData_valid  = (state_q == S_RD_RESP);
  assign readData_data   = rdata_q;
  assign writeResp_valid = (state_q == S_WR_RESP);
  assign writeResp_msg   = msg_q;

  assign mem_en    = ((state_q == S_RD_MEM) | (state_q == S_WR_MEM)) & ~oor_q;
  assign mem_we    = (state_q == S_WR_MEM);
  assign mem_addr  = line_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = strb_q;

  assign busy = ~is_idle;

endmodule

// File: tb/tb_axilite4_sram_ctrl.sv
`timescale 1ns/1ps
// Bench for axilite4_sram_ctrl: directed cases plus random traffic,
// checked every cycle against a transaction-level model.
module tb_axilite4_sram_ctrl;

  logic         clk;
  logic         rst;
  logic [31:0]  readAddr_addr;
  logic         readAddr_valid;
  logic         readAddr_ready;
  logic [127:0] readData_data;
  logic         readData_valid;
  logic         readData_ready;
  logic [31:0]  writeAddr_addr;
  logic         writeAddr_valid;
  logic         writeAddr_ready;
  logic [127:0] writeData_data;
  logic [15:0]  writeData_strb;
  logic         writeData_valid;
  logic         writeData_ready;
  logic [31:0]  writeResp_msg;
  logic         writeResp_valid;
  logic         writeResp_ready;
  logic         mem_en;
  logic         mem_we;
  logic [11:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_wmask;
  logic [127:0] mem_rdata;
  logic         busy;

  axilite4_sram_ctrl #(.memAddrWidth(16)) dut (
    .clk(clk), .rst(rst),
    .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid),
    .readAddr_ready(readAddr_ready),
    .readData_data(readData_data), .readData_valid(readData_valid),
    .readData_ready(readData_ready),
    .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid),
    .writeAddr_ready(writeAddr_ready),
    .writeData_data(writeData_data), .writeData_strb(writeData_strb),
    .writeData_valid(writeData_valid), .writeData_ready(writeData_ready),
    .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid),
    .writeResp_ready(writeResp_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic note_timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  function automatic logic [127:0] init_line(input int i);
    logic [31:0] x;
    x = i;
    return {x * 32'h9E3779B1, x * 32'h85EBCA6B ^ 32'h1234,
            x * 32'hC2B2AE35 + 32'h77, x ^ 32'hA5A5F00F};
  endfunction

  function automatic logic [127:0] merge(input logic [127:0] old,
                                         input logic [127:0] nw,
                                         input logic [15:0] m);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++)
      if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Macro model: synchronous single-port array, read data next cycle,
  // random junk on mem_rdata whenever no read was strobed.
  logic [127:0] sram [int];

  function automatic logic [127:0] sram_get(input int i);
    return sram.exists(i) ? sram[i] : init_line(i);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we)
      sram[int'(mem_addr)] = merge(sram_get(int'(mem_addr)), mem_wdata,
                                   mem_wmask);
    if (mem_en && !mem_we) mem_rdata <= sram_get(int'(mem_addr));
    else mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
  end

  // Reference model: contents updated at acceptance (strict ordering),
  // expected outputs derived from cycles elapsed since acceptance.
  logic [127:0] ref_mem [int];

  function automatic logic [127:0] ref_get(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : init_line(i);
  endfunction

  int           ph = -1;
  bit           last_wr = 1;
  bit           cur_rd;
  logic [11:0]  cur_line;
  bit           cur_inr;
  logic [127:0] cur_rdata;
  logic [127:0] cur_wdata;
  logic [15:0]  cur_strb;
  logic [31:0]  cur_msg;

  int          en_count = 0;
  logic [11:0] last_en_addr;
  logic [15:0] last_en_mask;
  int          grant_log [$];

  always @(negedge clk) begin
    bit rc, wc, e_ar, e_aw, e_en, e_we, e_rv, e_bv;
    if (started) begin
      e_ar = 0; e_aw = 0; e_en = 0; e_we = 0; e_rv = 0; e_bv = 0;
      if (ph < 0) begin
        rc = readAddr_valid;
        wc = writeAddr_valid && writeData_valid;
        e_ar = rc && (!wc || last_wr);
        e_aw = wc && !e_ar;
      end else if (cur_rd) begin
        e_en = (ph == 1) && cur_inr;
        e_rv = (ph >= 3);
      end else begin
        e_en = (ph == 1) && cur_inr;
        e_we = (ph == 1);
        e_bv = (ph >= 2);
      end
      chk("busy", busy, (ph >= 0));
      chk("readAddr_ready", readAddr_ready, e_ar);
      chk("writeAddr_ready", writeAddr_ready, e_aw);
      chk("writeData_ready", writeData_ready, e_aw);
      chk("mem_en", mem_en, e_en);
      chk("readData_valid", readData_valid, e_rv);
      chk("writeResp_valid", writeResp_valid, e_bv);
      if (ph == 1) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, cur_line);
        if (!cur_rd) begin
          chk("mem_wdata", mem_wdata, cur_wdata);
          chk("mem_wmask", mem_wmask, cur_strb);
        end
      end
      if (e_rv) chk("readData_data", readData_data, cur_rdata);
      if (e_bv) chk("writeResp_msg", writeResp_msg, cur_msg);

      if (mem_en === 1'b1) begin
        en_count++;
        last_en_addr = mem_addr;
        last_en_mask = mem_wmask;
      end
      if (readAddr_valid && readAddr_ready) grant_log.push_back(0);
      if (writeAddr_valid && writeAddr_ready) grant_log.push_back(1);

      if (rst) begin
        ph = -1;
        last_wr = 1;
      end else if (ph < 0) begin
        if (e_ar) begin
          cur_rd    = 1;
          cur_line  = readAddr_addr[15:4];
          cur_inr   = (readAddr_addr[31:16] == 16'h0);
          cur_rdata = cur_inr ? ref_get(int'(cur_line)) : '0;
          last_wr   = 0;
          ph        = 1;
        end else if (e_aw) begin
          cur_rd    = 0;
          cur_line  = writeAddr_addr[15:4];
          cur_inr   = (writeAddr_addr[31:16] == 16'h0);
          cur_wdata = writeData_data;
          cur_strb  = writeData_strb;
          cur_msg   = cur_inr ? 32'd0 : 32'd2;
          if (cur_inr)
            ref_mem[int'(cur_line)] = merge(ref_get(int'(cur_line)),
                                            cur_wdata, cur_strb);
          last_wr   = 1;
          ph        = 1;
        end
      end else if (cur_rd) begin
        if (ph >= 3 && readData_ready) ph = -1;
        else ph++;
      end else begin
        if (ph >= 2 && writeResp_ready) ph = -1;
        else ph++;
      end
    end
  end

  task automatic rd_txn(input logic [31:0] a, input int dly,
                        output logic [127:0] d);
    bit hs;
    hs = 0;
    d = '0;
    readAddr_addr = a;
    readAddr_valid = 1;
    for (int n = 0; n < 64 && !hs; n++) begin
      @(negedge clk);
      hs = readAddr_ready;
      @(posedge clk);
      #1;
    end
    readAddr_valid = 0;
    if (!hs) begin
      note_timeout("read_addr");
      return;
    end
    hs = 0;
    for (int n = 0; n < 64 && !hs; n++) begin
      readData_ready = (n >= dly);
      @(negedge clk);
      if (readData_valid && readData_ready) begin
        hs = 1;
        d = readData_data;
      end
      @(posedge clk);
      #1;
    end
    readData_ready = 0;
    if (!hs) note_timeout("read_data");
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [127:0] wd,
                        input logic [15:0] s, input int dly,
                        output logic [31:0] m);
    bit hs;
    hs = 0;
    m = '1;
    writeAddr_addr = a;
    writeData_data = wd;
    writeData_strb = s;
    writeAddr_valid = 1;
    writeData_valid = 1;
    for (int n = 0; n < 64 && !hs; n++) begin
      @(negedge clk);
      hs = writeAddr_ready;
      @(posedge clk);
      #1;
    end
    writeAddr_valid = 0;
    writeData_valid = 0;
    if (!hs) begin
      note_timeout("write_addr");
      return;
    end
    hs = 0;
    for (int n = 0; n < 64 && !hs; n++) begin
      writeResp_ready = (n >= dly);
      @(negedge clk);
      if (writeResp_valid && writeResp_ready) begin
        hs = 1;
        m = writeResp_msg;
      end
      @(posedge clk);
      #1;
    end
    writeResp_ready = 0;
    if (!hs) note_timeout("write_resp");
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 9) == 0)
      return {16'($urandom_range(1, 65535)), 16'($urandom)};
    return {16'h0, 4'h0, 8'($urandom_range(0, 15)), 4'($urandom)};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] PAT1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] PAT2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  initial begin
    logic [127:0] d, d2;
    logic [31:0]  m, m2;
    int           en0;
    bit           hs;

    rst = 1;
    readAddr_addr = 0; readAddr_valid = 0; readData_ready = 0;
    writeAddr_addr = 0; writeAddr_valid = 0;
    writeData_data = 0; writeData_strb = 0; writeData_valid = 0;
    writeResp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    started = 1;

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_readData_data", readData_data, 128'h0);
    chk("rst_writeResp_msg", writeResp_msg, 32'h0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rvalid", readData_valid, 1'b0);
    chk("rst_bvalid", writeResp_valid, 1'b0);
    @(posedge clk);
    #1;

    // Full-line write then read back.
    wr_txn(32'h20, PAT1, 16'hFFFF, 0, m);
    chk("t1_msg", m, 32'd0);
    chk("t1_mem_addr", last_en_addr, 12'd2);
    rd_txn(32'h20, 0, d);
    chk("t1_rdata", d, PAT1);

    // Partial strobe on a known line.
    wr_txn(32'h0, 128'h0, 16'hFFFF, 0, m);
    wr_txn(32'h0, '1, 16'h000F, 1, m);
    chk("t2_wmask", last_en_mask, 16'h000F);
    chk("t2_msg", m, 32'd0);
    rd_txn(32'h0, 0, d);
    chk("t2_rdata", d, 128'h00000000_00000000_00000000_FFFFFFFF);

    // Tie after reset: read first, then alternate.
    do_reset();
    grant_log.delete();
    fork
      begin
        rd_txn(32'h20, 0, d);
        rd_txn(32'h24, 0, d2);
      end
      begin
        wr_txn(32'h60, PAT2, 16'hFFFF, 0, m);
        wr_txn(32'h70, PAT2, 16'h00FF, 0, m2);
      end
    join
    chk("t3_grants", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      chk("t3_g0", grant_log[0], 0);
      chk("t3_g1", grant_log[1], 1);
      chk("t3_g2", grant_log[2], 0);
      chk("t3_g3", grant_log[3], 1);
    end
    chk("t3_rdata", d, PAT1);

    // Out-of-range accesses.
    en0 = en_count;
    rd_txn(32'h0001_0000, 0, d);
    chk("t4_rdata", d, 128'h0);
    wr_txn(32'h0001_0040, PAT2, 16'hFFFF, 0, m);
    chk("t4_msg", m, 32'd2);
    chk("t4_en_count", en_count, en0);

    // Read backpressure with a competing write held pending.
    fork
      rd_txn(32'h20, 7, d);
      wr_txn(32'h30, PAT2, 16'hFFFF, 0, m);
    join
    chk("t5_rdata", d, PAT1);
    chk("t5_msg", m, 32'd0);

    // Reset while the write sits in the macro cycle.
    writeAddr_addr = 32'h50;
    writeData_data = PAT2;
    writeData_strb = 16'hFFFF;
    writeAddr_valid = 1;
    writeData_valid = 1;
    hs = 0;
    for (int n = 0; n < 16 && !hs; n++) begin
      @(negedge clk);
      hs = writeAddr_ready;
      @(posedge clk);
      #1;
    end
    writeAddr_valid = 0;
    writeData_valid = 0;
    if (!hs) note_timeout("t6_write_addr");
    do_reset();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t6_busy", busy, 1'b0);
      chk("t6_bvalid", writeResp_valid, 1'b0);
      chk("t6_rdata_reg", readData_data, 128'h0);
      chk("t6_msg_reg", writeResp_msg, 32'h0);
      chk("t6_mem_en", mem_en, 1'b0);
      @(posedge clk);
      #1;
    end
    rd_txn(32'h50, 0, d);
    chk("t6_readback", d, PAT2);

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      logic [31:0]  a1, a2;
      logic [127:0] wd;
      logic [15:0]  ws;
      int           k, dl1, dl2;
      k   = $urandom_range(0, 2);
      a1  = rnd_addr();
      a2  = rnd_addr();
      wd  = {$urandom, $urandom, $urandom, $urandom};
      ws  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      dl1 = $urandom_range(0, 4);
      dl2 = $urandom_range(0, 4);
      if (k == 0) rd_txn(a1, dl1, d);
      else if (k == 1) wr_txn(a2, wd, ws, dl2, m);
      else begin
        fork
          rd_txn(a1, dl1, d);
          wr_txn(a2, wd, ws, dl2, m);
        join
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
